// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO: read-mode encodings and pointer wrap helper.
package fifo_pkg;

  localparam int FIFO_RD_STD  = 0;
  localparam int FIFO_RD_FWFT = 1;

  // Wrap by compare so depths that are not a power of two stay inside the array.
  function automatic int next_ptr(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_mem_sdp.sv
// Simple dual-port register array: one synchronous write port, one asynchronous read port.
module fifo_mem_sdp #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int AW         = 3
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_mode_s.sv
// Single-clock FIFO with standard or first-word-fall-through read, occupancy count and programmable flags.
// Define FIFO_MODE_S_ERR_EN to add sticky overflow/underflow error outputs.
module fifo_mode_s
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int FWFT_MODE  = FIFO_RD_STD,
  parameter int AF_LEVEL   = FIFO_DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_full,
  output logic                  o_wr_afull,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_empty,
  output logic                  o_rd_aempty,
  output logic [CNT_WIDTH-1:0]  o_count
`ifdef FIFO_MODE_S_ERR_EN
  ,
  output logic                  o_err_ovf,
  output logic                  o_err_udf
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW-1:0]         wr_addr;
  logic [AW-1:0]         rd_addr;
  logic [CNT_WIDTH-1:0]  count;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  full;
  logic                  empty;
  logic                  wr_acc;
  logic                  rd_acc;
  int                    count_int;

  // Flags come straight from the registered count, so they never glitch.
  assign count_int   = int'(count);
  assign full        = (count == CNT_WIDTH'(FIFO_DEPTH));
  assign empty       = (count == '0);
  assign o_wr_full   = full;
  assign o_rd_empty  = empty;
  assign o_wr_afull  = (count_int >= AF_LEVEL);
  assign o_rd_aempty = (count_int <= AE_LEVEL);
  assign o_count     = count;

  assign wr_acc = i_wr_en && !full && !i_rst;
  assign rd_acc = i_rd_en && !empty && !i_rst;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_addr <= '0;
      rd_addr <= '0;
      count   <= '0;
    end else begin
      if (wr_acc) begin
        wr_addr <= AW'(next_ptr(int'(wr_addr), FIFO_DEPTH));
      end
      if (rd_acc) begin
        rd_addr <= AW'(next_ptr(int'(rd_addr), FIFO_DEPTH));
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

  fifo_mem_sdp #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (FIFO_DEPTH),
    .AW        (AW)
  ) u_mem (
    .clk    (i_clk),
    .wr_en  (wr_acc),
    .wr_addr(wr_addr),
    .wr_data(i_wr_data),
    .rd_addr(rd_addr),
    .rd_data(mem_data)
  );

  generate
    if (FWFT_MODE == FIFO_RD_FWFT) begin : g_fwft
      // Head word is exposed directly; forced to zero while empty so reset shows 0.
      assign o_rd_data = empty ? '0 : mem_data;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rd_data_q;

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          rd_data_q <= '0;
        end else if (rd_acc) begin
          rd_data_q <= mem_data;
        end
      end

      assign o_rd_data = rd_data_q;
    end
  endgenerate

`ifdef FIFO_MODE_S_ERR_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_err_ovf <= 1'b0;
      o_err_udf <= 1'b0;
    end else begin
      if (i_wr_en && full) begin
        o_err_ovf <= 1'b1;
      end
      if (i_rd_en && empty) begin
        o_err_udf <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_mode_s.sv
// Bench for fifo_mode_s: standard-read table run, non-power-of-two wrap run and FWFT sequence.
// Build with FIFO_MODE_S_ERR_EN defined to also check the sticky error outputs.
module tb_fifo_mode_s;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: DEPTH 8, standard read
  logic        a_rst, a_wr_en, a_rd_en;
  logic [31:0] a_wr_data, a_rd_data;
  logic        a_full, a_afull, a_empty, a_aempty;
  logic [3:0]  a_count;
  // Instance B: DEPTH 6, standard read, 8-bit words
  logic        b_rst, b_wr_en, b_rd_en;
  logic [7:0]  b_wr_data, b_rd_data;
  logic        b_full, b_afull, b_empty, b_aempty;
  logic [2:0]  b_count;
  // Instance C: DEPTH 8, first-word-fall-through, 16-bit words
  logic        c_rst, c_wr_en, c_rd_en;
  logic [15:0] c_wr_data, c_rd_data;
  logic        c_full, c_afull, c_empty, c_aempty;
  logic [3:0]  c_count;
`ifdef FIFO_MODE_S_ERR_EN
  logic a_ovf, a_udf, b_ovf, b_udf, c_ovf, c_udf;
`endif

  fifo_mode_s #(.DATA_WIDTH(32), .FIFO_DEPTH(8), .FWFT_MODE(0)) u_std (
    .i_clk(clk), .i_rst(a_rst), .i_wr_en(a_wr_en), .i_wr_data(a_wr_data),
    .o_wr_full(a_full), .o_wr_afull(a_afull), .i_rd_en(a_rd_en),
    .o_rd_data(a_rd_data), .o_rd_empty(a_empty), .o_rd_aempty(a_aempty),
    .o_count(a_count)
`ifdef FIFO_MODE_S_ERR_EN
    , .o_err_ovf(a_ovf), .o_err_udf(a_udf)
`endif
  );

  fifo_mode_s #(.DATA_WIDTH(8), .FIFO_DEPTH(6), .FWFT_MODE(0)) u_wrap (
    .i_clk(clk), .i_rst(b_rst), .i_wr_en(b_wr_en), .i_wr_data(b_wr_data),
    .o_wr_full(b_full), .o_wr_afull(b_afull), .i_rd_en(b_rd_en),
    .o_rd_data(b_rd_data), .o_rd_empty(b_empty), .o_rd_aempty(b_aempty),
    .o_count(b_count)
`ifdef FIFO_MODE_S_ERR_EN
    , .o_err_ovf(b_ovf), .o_err_udf(b_udf)
`endif
  );

  fifo_mode_s #(.DATA_WIDTH(16), .FIFO_DEPTH(8), .FWFT_MODE(1)) u_fwft (
    .i_clk(clk), .i_rst(c_rst), .i_wr_en(c_wr_en), .i_wr_data(c_wr_data),
    .o_wr_full(c_full), .o_wr_afull(c_afull), .i_rd_en(c_rd_en),
    .o_rd_data(c_rd_data), .o_rd_empty(c_empty), .o_rd_aempty(c_aempty),
    .o_count(c_count)
`ifdef FIFO_MODE_S_ERR_EN
    , .o_err_ovf(c_ovf), .o_err_udf(c_udf)
`endif
  );

  // flags packed as {full, afull, empty, aempty}
  typedef struct {
    logic        rst;
    logic        wr;
    logic [31:0] data;
    logic        rd;
    int          cnt;
    logic [3:0]  flags;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] model_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_rd;
  logic        exp_ovf;
  logic        exp_udf;

  function automatic void addVec(input logic rst, input logic wr, input logic [31:0] data,
                                 input logic rd, input int cnt, input logic [3:0] flags);
    vec_t v;
    v.rst = rst; v.wr = wr; v.data = data; v.rd = rd; v.cnt = cnt; v.flags = flags;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one table row, update the scoreboard model, then sample after the edge.
  task automatic applyStimulus(input vec_t v);
    logic m_full, m_empty;
    @(negedge clk);
    a_rst = v.rst; a_wr_en = v.wr; a_wr_data = v.data; a_rd_en = v.rd;
    if (v.rst) begin
      model_q.delete();
      exp_q.delete();
      exp_q.push_back(32'h0);
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
    end else begin
      m_full  = (model_q.size() == 8);
      m_empty = (model_q.size() == 0);
      if (v.wr && m_full) exp_ovf = 1'b1;
      if (v.rd && m_empty) exp_udf = 1'b1;
      if (v.rd && !m_empty) exp_q.push_back(model_q.pop_front());
      if (v.wr && !m_full) model_q.push_back(v.data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cStep(input logic wr, input logic [15:0] data, input logic rd);
    @(negedge clk);
    c_wr_en = wr; c_wr_data = data; c_rd_en = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int sent, rcvd, bcnt;
    logic wacc, racc;

    a_rst = 1'b1; a_wr_en = 1'b0; a_rd_en = 1'b0; a_wr_data = '0;
    b_rst = 1'b1; b_wr_en = 1'b0; b_rd_en = 1'b0; b_wr_data = '0;
    c_rst = 1'b1; c_wr_en = 1'b0; c_rd_en = 1'b0; c_wr_data = '0;
    exp_rd = '0; exp_ovf = 1'b0; exp_udf = 1'b0;

    addVec(1, 0, 32'h00, 0, 0, 4'b0011);
    addVec(0, 1, 32'h11, 0, 1, 4'b0001);
    addVec(0, 1, 32'h22, 0, 2, 4'b0001);
    addVec(0, 1, 32'h33, 0, 3, 4'b0000);
    addVec(0, 1, 32'h44, 0, 4, 4'b0000);
    addVec(0, 1, 32'h55, 0, 5, 4'b0000);
    addVec(0, 1, 32'h66, 0, 6, 4'b0100);
    addVec(0, 1, 32'h77, 0, 7, 4'b0100);
    addVec(0, 1, 32'h88, 0, 8, 4'b1100);
    addVec(0, 1, 32'h99, 0, 8, 4'b1100);
    addVec(0, 0, 32'h00, 1, 7, 4'b0100);
    addVec(0, 0, 32'h00, 1, 6, 4'b0100);
    addVec(0, 0, 32'h00, 1, 5, 4'b0000);
    addVec(0, 0, 32'h00, 1, 4, 4'b0000);
    addVec(0, 0, 32'h00, 1, 3, 4'b0000);
    addVec(0, 0, 32'h00, 1, 2, 4'b0001);
    addVec(0, 0, 32'h00, 1, 1, 4'b0001);
    addVec(0, 0, 32'h00, 1, 0, 4'b0011);
    addVec(0, 0, 32'h00, 1, 0, 4'b0011);
    addVec(0, 1, 32'hA0, 1, 1, 4'b0001);
    addVec(0, 1, 32'hA1, 0, 2, 4'b0001);
    addVec(0, 1, 32'hA2, 0, 3, 4'b0000);
    addVec(0, 1, 32'hA3, 0, 4, 4'b0000);
    addVec(0, 1, 32'hB0, 1, 4, 4'b0000);
    addVec(0, 1, 32'hB1, 1, 4, 4'b0000);
    addVec(0, 1, 32'hB2, 1, 4, 4'b0000);
    addVec(0, 1, 32'hB3, 1, 4, 4'b0000);
    addVec(0, 1, 32'hC0, 0, 5, 4'b0000);
    addVec(0, 1, 32'hC1, 0, 6, 4'b0100);
    addVec(0, 1, 32'hC2, 0, 7, 4'b0100);
    addVec(0, 1, 32'hC3, 0, 8, 4'b1100);
    addVec(0, 1, 32'hDD, 1, 7, 4'b0100);
    addVec(0, 0, 32'h00, 1, 6, 4'b0100);
    addVec(0, 0, 32'h00, 1, 5, 4'b0000);
    addVec(1, 1, 32'h5A, 1, 0, 4'b0011);
    addVec(0, 1, 32'hEE, 0, 1, 4'b0001);
    addVec(0, 0, 32'h00, 1, 0, 4'b0011);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      if (i == 0) begin
        b_rst = 1'b0;
        c_rst = 1'b0;
      end
      if (exp_q.size() > 0) exp_rd = exp_q.pop_front();
      checkOutput($sformatf("row%0d_count", i), {28'h0, a_count}, vecs[i].cnt);
      checkOutput($sformatf("row%0d_flags", i), {28'h0, a_full, a_afull, a_empty, a_aempty},
                  {28'h0, vecs[i].flags});
      checkOutput($sformatf("row%0d_rd_data", i), a_rd_data, exp_rd);
`ifdef FIFO_MODE_S_ERR_EN
      checkOutput($sformatf("row%0d_err", i), {30'h0, a_ovf, a_udf}, {30'h0, exp_ovf, exp_udf});
`endif
    end
    a_wr_en = 1'b0; a_rd_en = 1'b0;

    // Depth-6 wrap: words 0..19 with random write/read gaps
    checkOutput("wrap_reset_flags", {28'h0, b_full, b_afull, b_empty, b_aempty}, 32'h3);
    sent = 0; rcvd = 0; bcnt = 0;
    for (int cyc = 0; cyc < 2000 && rcvd < 20; cyc++) begin
      @(negedge clk);
      b_wr_en   = (sent < 20) && ($urandom_range(0, 2) != 0);
      b_wr_data = sent[7:0];
      b_rd_en   = ($urandom_range(0, 2) != 0);
      wacc = b_wr_en && (bcnt != 6);
      racc = b_rd_en && (bcnt != 0);
      @(posedge clk);
      #1;
      if (wacc) begin sent++; bcnt++; end
      if (racc) begin
        checkOutput($sformatf("wrap_data%0d", rcvd), {24'h0, b_rd_data}, rcvd);
        rcvd++;
        bcnt--;
      end
      checkOutput("wrap_count", {29'h0, b_count}, bcnt);
      checkOutput("wrap_flags", {28'h0, b_full, b_afull, b_empty, b_aempty},
                  {28'h0, bcnt == 6, bcnt >= 4, bcnt == 0, bcnt <= 2});
    end
    checkOutput("wrap_received", rcvd, 20);
    b_wr_en = 1'b0; b_rd_en = 1'b0;

    // FWFT: written word appears without a read, pop empties
    checkOutput("fwft_reset_empty", {31'h0, c_empty}, 32'h1);
    cStep(1, 16'hCAFE, 0);
    checkOutput("fwft_empty_after_wr", {31'h0, c_empty}, 32'h0);
    checkOutput("fwft_head", {16'h0, c_rd_data}, 32'hCAFE);
    checkOutput("fwft_count1", {28'h0, c_count}, 32'h1);
    cStep(0, 16'h0, 0);
    checkOutput("fwft_head_hold", {16'h0, c_rd_data}, 32'hCAFE);
    cStep(0, 16'h0, 1);
    checkOutput("fwft_pop_empty", {31'h0, c_empty}, 32'h1);
    checkOutput("fwft_pop_count", {28'h0, c_count}, 32'h0);
    cStep(1, 16'h1234, 0);
    cStep(1, 16'h5678, 0);
    checkOutput("fwft_head2", {16'h0, c_rd_data}, 32'h1234);
    checkOutput("fwft_count2", {28'h0, c_count}, 32'h2);
    cStep(0, 16'h0, 1);
    checkOutput("fwft_head3", {16'h0, c_rd_data}, 32'h5678);
    cStep(0, 16'h0, 1);
    checkOutput("fwft_final_empty", {31'h0, c_empty}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_mode_s.md
Name: fifo_mode_s

Overview:
- Single-clock synchronous FIFO. Successor to the dual-clock FIFO for same-domain buffering.
- Generalised over data width and depth. Depth need not be a power of two.
- Adds a selectable read mode (standard or first-word-fall-through), an occupancy count, and programmable almost-full/almost-empty flags.
- Sits between producer/consumer pipeline stages inside one clock domain.

Parameters:
- DATA_WIDTH, 32, width of each stored word.
- FIFO_DEPTH, 8, number of entries; legal range 2..1024, any integer.
- FWFT_MODE, 0, 0 = standard read (data one cycle after accepted read); 1 = first-word-fall-through.
- AF_LEVEL, FIFO_DEPTH-2, o_wr_afull asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, o_rd_aempty asserts when count <= AE_LEVEL.
- CNT_WIDTH, $clog2(FIFO_DEPTH+1), width of occupancy count (derived; not overridden).

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_wr_en  input  1  write request.
- i_wr_data  input  DATA_WIDTH  write word.
- o_wr_full  output  1  no free entry.
- o_wr_afull  output  1  count >= AF_LEVEL.
- i_rd_en  input  1  read request (FWFT: pop/acknowledge).
- o_rd_data  output  DATA_WIDTH  read word.
- o_rd_empty  output  1  no valid entry.
- o_rd_aempty  output  1  count <= AE_LEVEL.
- o_count  output  CNT_WIDTH  current occupancy, 0..FIFO_DEPTH.

Behaviour:
- Reset (i_rst=1 at clock edge):
  - Pointers and count go to 0.
  - o_rd_empty=1, o_wr_full=0, o_rd_aempty=1, o_wr_afull=(AF_LEVEL==0), o_rd_data=0.
  - Memory contents are not cleared.
  - Reset mid-operation discards all entries in that cycle; requests in the reset cycle are ignored.
- Write acceptance:
  - wr_acc = i_wr_en && !o_wr_full.
  - On acceptance: mem[wr_addr] <= i_wr_data, and wr_addr advances.
- Read acceptance:
  - rd_acc = i_rd_en && !o_rd_empty.
  - On acceptance, rd_addr advances.
- Full/empty are evaluated on the registered state before the edge:
  - Write while full is rejected even if a read is accepted in the same cycle.
  - Read while empty is rejected even if a write is accepted in the same cycle.
- Pointer wrap: addresses are $clog2(FIFO_DEPTH) bits; at FIFO_DEPTH-1 they wrap to 0 explicitly (compare, not bit truncation).
- Count update:
  - +1 on wr_acc only; -1 on rd_acc only; unchanged on both or neither.
  - o_wr_full = (count==FIFO_DEPTH); o_rd_empty = (count==0).
  - All flags derive from the registered count and are glitch-free.
- FWFT_MODE=0:
  - o_rd_data <= mem[rd_addr] on rd_acc; read latency 1 cycle.
  - o_rd_data holds its value when there is no rd_acc.
- FWFT_MODE=1:
  - o_rd_data = mem[rd_addr] continuously; valid whenever o_rd_empty=0.
  - A word written into an empty FIFO appears on o_rd_data with o_rd_empty=0 one cycle after the write edge.
  - i_rd_en pops the head word.
  - o_rd_data is don't-care while empty.
- Overflow/underflow requests are silently dropped unless the error feature is built in.

Optional Feature:
- Macro: FIFO_MODE_S_ERR_EN.
- When defined, adds output ports o_err_ovf and o_err_udf (1 bit each, reset 0):
  - o_err_ovf sets sticky on i_wr_en && o_wr_full.
  - o_err_udf sets sticky on i_rd_en && o_rd_empty.
  - Both clear only on i_rst.
- When undefined, these ports and their logic do not exist; dropped requests leave no trace.

Decomposition:
- Shared package fifo_pkg holds:
  - the FWFT_MODE encodings (FIFO_RD_STD=0, FIFO_RD_FWFT=1);
  - a function for the next pointer with non-power-of-two wrap.
- One sub-module, fifo_mem_sdp: simple dual-port register array.
  - One write port: clk, en, addr, data.
  - One asynchronous read port: addr -> data.
- Pointer/count/flag control and the read-mode output stage stay in fifo_mode_s.

Test Plan:
- Reset, then 8 writes of 0x11..0x88 (DEPTH=8, FWFT=0):
  - o_count steps 1..8; o_wr_afull asserts at count 6; o_wr_full asserts after the 8th write.
  - A 9th write of 0x99 is dropped; o_count stays 8.
- Drain the full FIFO with i_rd_en=1 for 8 cycles (FWFT=0):
  - o_rd_data shows 0x11..0x88, each 1 cycle after its read; o_rd_aempty asserts at count 2.
  - o_rd_empty asserts at count 0; a further read leaves o_rd_data=0x88.
- Simultaneous i_wr_en and i_rd_en with count=4: count stays 4 and order is preserved.
  - At count=0: only the write is accepted, count becomes 1.
  - At count=8: only the read is accepted, count becomes 7.
- Non-power-of-two wrap (DEPTH=6): push/pop 20 words 0..19 with random gaps; all 20 come out in order and no flag errors occur across repeated wrap at address 5->0.
- FWFT=1, single write of 0xCAFE into an empty FIFO:
  - The next cycle shows o_rd_empty=0 and o_rd_data=0xCAFE with no read issued.
  - A pop returns the FIFO to empty.
- i_rst asserted with count=5 mid-stream:
  - Next cycle shows count=0, o_rd_empty=1, o_rd_data=0.
  - With FIFO_MODE_S_ERR_EN built in, an earlier read-while-empty sets o_err_udf, and it clears only on this reset.
